// File: rtl/voice_sched_pkg.sv
// Shared types and default sizing for the voice scheduler.
// The release-tail behaviour is selected by the VOICE_SCHED_RELEASE_EN macro.
package voice_sched_pkg;

    localparam int NVOICE_DEF  = 4;
    localparam int PHASE_W_DEF = 16;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    function automatic int slot_width(input int nvoice);
        return (nvoice > 1) ? $clog2(nvoice) : 1;
    endfunction

endpackage

// File: rtl/voice_phase.sv
// Per-voice phase accumulator with active flag; the carry out of the phase add ends a
// released voice when VOICE_SCHED_RELEASE_EN is defined.
module voice_phase
    import voice_sched_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_key,
    input  logic               i_step,
    input  logic [PHASE_W-1:0] i_inc,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_active
);

    logic [PHASE_W-1:0] r_phase;
    logic               r_active;
    logic               r_released;
    logic [PHASE_W:0]   w_sum;
    logic               w_carry;

    assign w_sum    = {1'b0, r_phase} + {1'b0, i_inc};
    assign w_carry  = w_sum[PHASE_W];
    assign o_addr   = r_phase[PHASE_W-1 -: ADDR_W];
    assign o_active = r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_active   <= 1'b0;
            r_released <= 1'b0;
        end else if (i_start) begin
            if (i_key) begin
                // A fresh press, or a re-press during the release tail, restarts the phase.
                if (!r_active || r_released) begin
                    r_active <= 1'b1;
                    r_phase  <= '0;
                end
                r_released <= 1'b0;
            end else begin
`ifdef VOICE_SCHED_RELEASE_EN
                r_released <= 1'b1;
`else
                r_active   <= 1'b0;
`endif
            end
        end else if (i_step && r_active) begin
            r_phase <= w_sum[PHASE_W-1:0];
            if (r_released && w_carry) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/voice_sched.sv
// Time-multiplexed wavetable voice scheduler: one ROM read slot per voice per sample tick.
// Define VOICE_SCHED_RELEASE_EN to let released voices play out until their phase wraps.
module voice_sched
    import voice_sched_pkg::*;
#(
    parameter int NVOICE  = NVOICE_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic [NVOICE-1:0]             key_on,
    input  logic [NVOICE*PHASE_W-1:0]     phase_inc,
    output logic                          rom_rd,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic [DATA_W+$clog2(NVOICE)-1:0] mix,
    output logic                          mix_valid,
    output logic                          busy,
    output logic [NVOICE-1:0]             voice_active,
    output logic                          overrun
);

    localparam int MIX_W  = DATA_W + $clog2(NVOICE);
    localparam int SLOT_W = slot_width(NVOICE);

    state_e              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_rd_d;
    logic [MIX_W-1:0]    r_acc;
    logic [MIX_W-1:0]    r_mix;
    logic                r_mix_valid;
    logic                r_busy;
    logic                r_overrun;

    logic                w_accept;
    logic [NVOICE-1:0]   w_step;
    logic [NVOICE-1:0]   w_active;
    logic [ADDR_W-1:0]   w_addr [NVOICE];
    logic                w_rom_rd;
    logic [ADDR_W-1:0]   w_rom_addr;

    assign w_accept = tick && (r_state == IDLE);

    for (genvar g = 0; g < NVOICE; g++) begin : g_voice
        assign w_step[g] = (r_state == SCAN) && (r_slot == SLOT_W'(g));

        voice_phase #(
            .PHASE_W (PHASE_W),
            .ADDR_W  (ADDR_W)
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_start  (w_accept),
            .i_key    (key_on[g]),
            .i_step   (w_step[g]),
            .i_inc    (phase_inc[g*PHASE_W +: PHASE_W]),
            .o_addr   (w_addr[g]),
            .o_active (w_active[g])
        );
    end

    // The ROM port is a pure decode of the current slot, so it drops to 0 the moment reset hits.
    always_comb begin
        w_rom_rd   = 1'b0;
        w_rom_addr = '0;
        if (r_state == SCAN) begin
            w_rom_rd   = w_active[r_slot];
            w_rom_addr = w_addr[r_slot];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_slot      <= '0;
            r_rd_d      <= 1'b0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            r_overrun   <= tick && (r_state != IDLE);
            r_rd_d      <= w_rom_rd;
            // rom_data belongs to the read issued one cycle earlier; r_rd_d tracks that.
            if (r_rd_d) begin
                r_acc <= r_acc + MIX_W'(rom_data);
            end
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_state <= SCAN;
                        r_slot  <= '0;
                        r_busy  <= 1'b1;
                        r_acc   <= '0;
                    end
                end
                SCAN: begin
                    if (r_slot == SLOT_W'(NVOICE - 1)) begin
                        r_state <= DRAIN;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                DRAIN: begin
                    r_state <= OUT;
                end
                OUT: begin
                    r_mix       <= r_acc;
                    r_mix_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rom_rd       = w_rom_rd;
    assign rom_addr     = w_rom_addr;
    assign mix          = r_mix;
    assign mix_valid    = r_mix_valid;
    assign busy         = r_busy;
    assign voice_active = w_active;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_voice_sched.sv
// Bench for voice_sched: ROM returns its own address one cycle after each read; a per-tick
// reference model tracks phases, active flags and release state from the voice rules.
module tb_voice_sched;

    localparam int NV = 4;
    localparam int PW = 16;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MW = 10;
`ifdef VOICE_SCHED_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic [NV-1:0]     key_on;
    logic [NV*PW-1:0]  phase_inc;
    logic              rom_rd;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [MW-1:0]     mix;
    logic              mix_valid;
    logic              busy;
    logic [NV-1:0]     voice_active;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int unsigned       m_ph  [NV];
    bit                m_act [NV];
    bit                m_rel [NV];
    logic [MW-1:0]     exp_mix;
    logic [AW-1:0]     exp_q [$];
    logic [AW-1:0]     obs_q [$];

    voice_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .key_on       (key_on),
        .phase_inc    (phase_inc),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .mix          (mix),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .voice_active (voice_active),
        .overrun      (overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ROM model: rom[a] = a, one-cycle latency
    always @(posedge clk) rom_data <= rom_addr;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_ph[i]  = 0;
            m_act[i] = 1'b0;
            m_rel[i] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        tick      = 1'b0;
        key_on    = '0;
        phase_inc = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // ---------------- reference model ----------------
    task automatic model_tick(input logic [NV-1:0] keys, input logic [NV*PW-1:0] incs);
        int unsigned sum;
        int unsigned nxt;
        sum = 0;
        exp_q.delete();
        for (int i = 0; i < NV; i++) begin
            if (keys[i]) begin
                if (!m_act[i] || m_rel[i]) begin
                    m_act[i] = 1'b1;
                    m_ph[i]  = 0;
                end
                m_rel[i] = 1'b0;
            end else if (REL_EN) begin
                m_rel[i] = 1'b1;
            end else begin
                m_act[i] = 1'b0;
            end
        end
        for (int i = 0; i < NV; i++) begin
            if (m_act[i]) begin
                exp_q.push_back(AW'(m_ph[i] / 256));
                sum = sum + m_ph[i] / 256;
                nxt = m_ph[i] + 32'(incs[i*PW +: PW]);
                if (m_rel[i] && nxt >= 65536) m_act[i] = 1'b0;
                m_ph[i] = nxt % 65536;
            end
        end
        exp_mix = MW'(sum);
    endtask

    function automatic logic [NV-1:0] model_active();
        logic [NV-1:0] a;
        for (int i = 0; i < NV; i++) a[i] = m_act[i];
        return a;
    endfunction

    // ---------------- driver ----------------
    // Issues one tick, records ROM addresses, counts overrun pulses, and returns the cycle
    // count from accept to mix_valid (-1 if it never came). ovr_at injects a second tick.
    task automatic run_tick(input logic [NV-1:0] keys, input int ovr_at,
                            output logic [MW-1:0] got_mix, output int lat, output int n_ovr);
        obs_q.delete();
        lat     = -1;
        n_ovr   = 0;
        got_mix = '0;
        @(negedge clk);
        tick   = 1'b1;
        key_on = keys;
        @(negedge clk);
        tick = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (rom_rd) obs_q.push_back(rom_addr);
            if (overrun) n_ovr++;
            if (mix_valid) begin
                lat     = k;
                got_mix = mix;
                break;
            end
            if (k == ovr_at) tick = 1'b1;
            if (k == ovr_at + 1) tick = 1'b0;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++; if (mix !== '0) begin n_fail++; $display("FAIL reset_mix: got %0d expected 0", mix); end
        n_checks++; if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mix_valid: got %b expected 0", mix_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (voice_active !== '0) begin n_fail++; $display("FAIL reset_active: got %b expected 0000", voice_active); end
        n_checks++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rd: got %b expected 0", rom_rd); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_silent_tick();
        logic [MW-1:0] got;
        int lat, novr;
        apply_reset();
        phase_inc = {$urandom, $urandom};
        run_tick(4'b0000, -1, got, lat, novr);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL silent_rom_rd: got %0d reads expected 0", obs_q.size()); end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL silent_latency: got %0d expected 6", lat); end
        n_checks++; if (got !== '0) begin n_fail++; $display("FAIL silent_mix: got %0d expected 0", got); end
    endtask

    task automatic test_single_voice();
        logic [MW-1:0] got;
        int lat, novr;
        apply_reset();
        phase_inc = {$urandom, $urandom};
        phase_inc[PW-1:0] = 16'h0100;
        for (int t = 0; t < 5; t++) begin
            run_tick(4'b0001, -1, got, lat, novr);
            n_checks++; if (got !== MW'(t)) begin n_fail++; $display("FAIL single_mix[%0d]: got %0d expected %0d", t, got, t); end
            n_checks++; if (obs_q.size() != 1 || obs_q[0] !== AW'(t)) begin
                n_fail++; $display("FAIL single_addr[%0d]: got %0d reads first %0d expected 1 read of %0d",
                                   t, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'h00, t);
            end
        end
    endtask

    task automatic test_all_voices();
        logic [MW-1:0] got;
        logic [MW-1:0] want;
        int lat, novr;
        apply_reset();
        phase_inc = {4{16'h4000}};
        for (int t = 0; t < 5; t++) begin
            want = MW'(256 * (t % 4));
            run_tick(4'b1111, -1, got, lat, novr);
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL all_mix[%0d]: got %0d expected %0d", t, got, want); end
        end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL all_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_overrun();
        logic [MW-1:0] got;
        logic [NV-1:0] keys;
        int lat, novr, extra;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            keys      = NV'($urandom_range(1, 15));
            phase_inc = {$urandom, $urandom};
            model_tick(keys, phase_inc);
            run_tick(keys, 1, got, lat, novr);
            n_checks++; if (novr != 1) begin n_fail++; $display("FAIL overrun_pulses[%0d]: got %0d expected 1", r, novr); end
            n_checks++; if (lat != 6) begin n_fail++; $display("FAIL overrun_latency[%0d]: got %0d expected 6", r, lat); end
            n_checks++; if (got !== exp_mix) begin n_fail++; $display("FAIL overrun_mix[%0d]: got %0d expected %0d", r, got, exp_mix); end
            extra = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (mix_valid) extra++;
                if (overrun) extra++;
            end
            n_checks++; if (extra != 0) begin n_fail++; $display("FAIL overrun_extra_pulses[%0d]: got %0d expected 0", r, extra); end
        end
    endtask

    task automatic test_release();
        logic [MW-1:0] got;
        logic [MW-1:0] want;
        int lat, novr;
        apply_reset();
        phase_inc = {$urandom, $urandom};
        phase_inc[PW-1:0] = 16'h4000;
        for (int t = 0; t < 3; t++) begin
            run_tick(4'b0001, -1, got, lat, novr);
            n_checks++; if (got !== MW'(64 * t)) begin n_fail++; $display("FAIL release_hold_mix[%0d]: got %0d expected %0d", t, got, 64 * t); end
        end
        want = REL_EN ? MW'(192) : MW'(0);
        run_tick(4'b0000, -1, got, lat, novr);
        n_checks++; if (got !== want) begin n_fail++; $display("FAIL release_tail_mix: got %0d expected %0d", got, want); end
        n_checks++; if (voice_active[0] !== 1'b0) begin n_fail++; $display("FAIL release_active: got %b expected 0", voice_active[0]); end
        run_tick(4'b0000, -1, got, lat, novr);
        n_checks++; if (got !== '0) begin n_fail++; $display("FAIL release_after_mix: got %0d expected 0", got); end
    endtask

    task automatic test_random();
        logic [MW-1:0] got;
        logic [NV-1:0] keys;
        int lat, novr, bad;
        apply_reset();
        for (int r = 0; r < 30; r++) begin
            keys = NV'($urandom_range(0, 15));
            if (r % 3 != 0) phase_inc = {$urandom, $urandom};
            model_tick(keys, phase_inc);
            run_tick(keys, -1, got, lat, novr);
            n_checks++; if (lat != 6) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 6", r, lat); end
            n_checks++; if (got !== exp_mix) begin n_fail++; $display("FAIL rand_mix[%0d]: got %0d expected %0d", r, got, exp_mix); end
            bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < obs_q.size() && bad == 0; i++) begin
                if (obs_q[i] !== exp_q[i]) bad = 1;
            end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0d reads expected %0d reads or address differs", r, obs_q.size(), exp_q.size()); end
            n_checks++; if (voice_active !== model_active()) begin n_fail++; $display("FAIL rand_active[%0d]: got %b expected %b", r, voice_active, model_active()); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [MW-1:0] got;
        int lat, novr, nvalid;
        apply_reset();
        phase_inc = {4{16'h4000}};
        run_tick(4'b1111, -1, got, lat, novr);
        run_tick(4'b1111, -1, got, lat, novr);
        n_checks++; if (got !== MW'(256)) begin n_fail++; $display("FAIL midrst_pre_mix: got %0d expected 256", got); end
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rom_rd !== 1'b1) begin n_fail++; $display("FAIL midrst_slot2_rd: got %b expected 1", rom_rd); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rom_rd !== 1'b0 || rom_addr !== '0) begin n_fail++; $display("FAIL midrst_rom: got rd %b addr %0d expected 0 0", rom_rd, rom_addr); end
        n_checks++; if (mix !== '0 || mix_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_mix: got %0d valid %b expected 0 0", mix, mix_valid); end
        n_checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got busy %b overrun %b expected 0 0", busy, overrun); end
        n_checks++; if (voice_active !== '0) begin n_fail++; $display("FAIL midrst_active: got %b expected 0000", voice_active); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mix_valid) nvalid++;
        end
        n_checks++; if (nvalid != 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d expected 0", nvalid); end
        model_tick(4'b1111, phase_inc);
        run_tick(4'b1111, -1, got, lat, novr);
        n_checks++; if (got !== exp_mix) begin n_fail++; $display("FAIL midrst_restart_mix: got %0d expected %0d", got, exp_mix); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        key_on    = '0;
        phase_inc = '0;
        test_reset();
        test_silent_tick();
        test_single_voice();
        test_all_voices();
        test_overrun();
        test_release();
        test_random();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_sched.md
VOICE_SCHED -- requirements
Module: voice_sched

Interface
REQ-001 SHALL have parameter NVOICE, default 4: number of voices sharing the waveform ROM.
REQ-002 SHALL have parameter PHASE_W, default 16: phase accumulator width.
REQ-003 SHALL have parameter ADDR_W, default 8: ROM address width, equal to phase[PHASE_W-1 -: ADDR_W].
REQ-004 SHALL have parameter DATA_W, default 8: ROM sample width, unsigned.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port tick, input, 1: sample-rate strobe, one cycle wide.
REQ-008 SHALL have port key_on, input, NVOICE: level per voice, 1 = key held.
REQ-009 SHALL have port phase_inc, input, NVOICE*PHASE_W: per-voice increment; voice i occupies bits [i*PHASE_W +: PHASE_W].
REQ-010 SHALL have port rom_rd, output, 1: ROM read strobe.
REQ-011 SHALL have port rom_addr, output, ADDR_W: ROM address.
REQ-012 SHALL have port rom_data, input, DATA_W: ROM data, valid one cycle after rom_rd.
REQ-013 SHALL have port mix, output, DATA_W+$clog2(NVOICE): registered sum of voice samples.
REQ-014 SHALL have port mix_valid, output, 1: one-cycle pulse when mix updates.
REQ-015 SHALL have port busy, output, 1: high while a scan is in progress.
REQ-016 SHALL have port voice_active, output, NVOICE: voices currently sounding.
REQ-017 SHALL have port overrun, output, 1: one-cycle pulse when tick arrives while busy.

Function
REQ-018 SHALL use FSM states IDLE, SCAN, DRAIN, OUT: tick in IDLE->SCAN; SCAN lasts NVOICE cycles, slot i serving voice i; then DRAIN for 1 cycle; then OUT for 1 cycle; then IDLE.
REQ-019 SHALL sample key_on only in the cycle tick is accepted.
REQ-020 SHALL, on accept, set voice_active[i] and zero phase_i for each voice with key_on[i]=1 and voice_active[i]=0, including a voice re-pressed during release.
REQ-021 SHALL, in slot i with voice_active[i]=1, assert rom_rd and drive rom_addr=phase_i[PHASE_W-1 -: ADDR_W], then update phase_i += phase_inc_i modulo 2^PHASE_W.
REQ-022 SHALL, in slot i with voice i inactive, keep rom_rd=0 and contribute 0 to the sum; the slot is still consumed, so latency is fixed.
REQ-023 SHALL accumulate rom_data in the cycle after each rom_rd, with no overflow in full width.
REQ-024 SHALL, in OUT, register mix and pulse mix_valid; mix_valid is therefore asserted exactly NVOICE+2 cycles after the accepted tick.
REQ-025 SHALL ignore a tick in any state other than IDLE, pulse overrun, and leave the running scan unaffected.
REQ-026 SHALL drive busy=1 in SCAN, DRAIN and OUT.
REQ-027 SHALL keep rom_rd=0 outside SCAN.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-scan, reset state to IDLE, and clear all phase_i, voice_active, the accumulator, mix, mix_valid, rom_rd, rom_addr, busy and overrun to 0.
REQ-029 SHALL, after rst_n deasserts, discard any ROM data returned for an aborted read.

Configuration
REQ-030 SHALL, with VOICE_SCHED_RELEASE_EN undefined, clear voice_active[i] on accept when key_on[i]=0; voice i contributes 0 in that scan.
REQ-031 SHALL, with VOICE_SCHED_RELEASE_EN defined, keep a released voice active and reading until its phase addition carries out of PHASE_W, then clear voice_active[i] after that slot; the wrapping sample is still output.

Structure
REQ-032 SHALL place the FSM state enum and the default NVOICE/PHASE_W/ADDR_W/DATA_W constants in package voice_sched_pkg.
REQ-033 SHALL instantiate one sub-module, voice_phase (per-voice phase accumulator with active flag and carry-out), NVOICE times.

Verification (ROM model: rom[a]=a, 1-cycle latency, default parameters)
REQ-034 SHALL check: reset, key_on=0, tick -> rom_rd never asserted; mix=0 with mix_valid 6 cycles after tick.
REQ-035 SHALL check: voice0 key_on, inc=0x0100, 5 ticks -> mix=0,1,2,3,4; rom_addr matches.
REQ-036 SHALL check: all 4 voices on, inc=0x4000, 5 ticks -> mix=0,256,512,768,0.
REQ-037 SHALL check: tick repeated 2 cycles after a tick -> overrun pulses once; exactly one mix_valid per accepted tick.
REQ-038 SHALL check: voice0 inc=0x4000, key released at the tick where phase=0xC000 -> with macro, mix=192 then voice_active[0]=0 and next mix=0; without macro, mix=0 immediately.
REQ-039 SHALL check: rst_n pulsed low during SCAN slot 2 -> all outputs 0 immediately; no mix_valid for that scan.
